// File: rtl/dma_fifo_drain.sv
// dma_fifo_drain
// Read-side engine of the DMA word FIFO. Pops one word at a time from the
// FIFO and writes it to consecutive word addresses over an OBI manager port.
// Only one bus transaction is in flight at any time.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 start a transfer (sampled only when idle)
//   dst_addr_i, len_i       destination byte address (low 2 bits dropped), word count
//   busy_o, done_o          engine active / one-cycle end-of-transfer pulse
//   error_o                 sticky bus error, cleared by the next accepted start
//   fifo_rd_en_o            FIFO pop strobe
//   fifo_rd_data_i          FIFO head word (valid while !fifo_empty_i)
//   fifo_empty_i            FIFO empty flag
//   obi_*                   OBI manager write port
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i
// FETCH  | popping the next word from the FIFO (stalls while empty)
// REQ    | write request on the bus, held until granted
// RSP    | waiting for the write response
// DONE   | one-cycle done pulse, then back to IDLE

module dma_fifo_drain #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    error_o,
   output logic                    fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0]   fifo_rd_data_i,
   input  logic                    fifo_empty_i,
   output logic                    obi_req_o,
   input  logic                    obi_gnt_i,
   output logic [ADDR_WIDTH-1:0]   obi_addr_o,
   output logic                    obi_we_o,
   output logic [DATA_WIDTH/8-1:0] obi_be_o,
   output logic [DATA_WIDTH-1:0]   obi_wdata_o,
   input  logic                    obi_rvalid_i,
   input  logic                    obi_err_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_REQ,
      S_RSP,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
   logic [LEN_WIDTH-1:0]    rem_q,   rem_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    error_q, error_d;
   logic                    pop;

   // Destination is word aligned; the byte offset bits are intentionally dropped.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^dst_addr_i[1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         wdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wdata_q <= wdata_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      wdata_d = wdata_q;
      error_d = error_q;
      pop     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               addr_d  = {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
               rem_d   = len_i;
               error_d = 1'b0;
               // A zero-length transfer finishes without touching FIFO or bus.
               state_d = (len_i != '0) ? S_FETCH : S_DONE;
            end
         end
         S_FETCH: begin
            if (!fifo_empty_i) begin
               pop     = 1'b1;
               wdata_d = fifo_rd_data_i;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (obi_gnt_i) state_d = S_RSP;
         end
         S_RSP: begin
            if (obi_rvalid_i) begin
               if (obi_err_i) begin
                  // Abort: remaining FIFO words stay where they are.
                  error_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  rem_d   = rem_q - LEN_WIDTH'(1);
                  addr_d  = addr_q + ADDR_WIDTH'(4);
                  state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus outputs are gated by the request so everything reads zero outside REQ.
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign error_o      = error_q;
   assign fifo_rd_en_o = pop;
   assign obi_req_o    = (state_q == S_REQ);
   assign obi_we_o     = obi_req_o;
   assign obi_be_o     = {(DATA_WIDTH/8){obi_req_o}};
   assign obi_addr_o   = obi_req_o ? addr_q  : '0;
   assign obi_wdata_o  = obi_req_o ? wdata_q : '0;

endmodule
